// File: rtl/vga_fill_engine.sv
// rtl/vga_fill_engine.sv - bus-mapped rectangle fill engine for the 160x120 frame buffer (optional IRQ via VGA_FILL_IRQ_EN)
module vga_fill_engine #(
    parameter logic [7:0] BaseAddr = 8'hC0,
    parameter int         X_MAX    = 159,
    parameter int         Y_MAX    = 119
) (
    input  logic        CLK,
    input  logic        RESET,
    inout  wire  [7:0]  BUS_DATA,
    input  logic [7:0]  BUS_ADDR,
    input  logic        BUS_WE,
    output logic [14:0] FB_ADDR,
    output logic        FB_DATA,
    output logic        FB_WE,
`ifdef VGA_FILL_IRQ_EN
    output logic        IRQ_RAISE,
    input  logic        IRQ_ACKED,
`endif
    output logic        BUSY
);

    localparam logic [7:0] XM = X_MAX[7:0];
    localparam logic [7:0] YM = Y_MAX[7:0];

    typedef enum logic {IDLE, FILL} state_t;

    state_t      state;
    logic [7:0]  x0, y0, x1, y1;
    logic        ctrl_val;
    logic        err;
    logic        busy;
    logic        fb_we;
    logic        fill_val;
    logic [7:0]  cx, lx0, lx1;
    logic [6:0]  cy, ly1;
    logic        rd_en;
    logic [7:0]  rd_data;

    // Address decode relative to the block base
    logic [8:0]  rel;
    logic        in_range;
    logic [2:0]  offset;
    logic        bus_wr;
    logic        start;
    logic        start_ok;
    logic        fill_last;

    assign rel       = {1'b0, BUS_ADDR} - {1'b0, BaseAddr};
    assign in_range  = (BUS_ADDR >= BaseAddr) && (rel < 9'd6);
    assign offset    = rel[2:0];
    assign bus_wr    = BUS_WE && in_range;
    assign start     = bus_wr && (offset == 3'd4) && BUS_DATA[7] && (state == IDLE);
    assign start_ok  = (x0 <= x1) && (x1 <= XM) && (y0 <= y1) && (y1 <= YM);
    assign fill_last = (state == FILL) && (cx == lx1) && (cy == ly1);

    // Programmable registers; frozen while a fill runs so the bus cannot disturb it
    always_ff @(posedge CLK) begin
        if (RESET) begin
            x0       <= 8'd0;
            y0       <= 8'd0;
            x1       <= 8'd0;
            y1       <= 8'd0;
            ctrl_val <= 1'b0;
        end else if (bus_wr && !busy) begin
            case (offset)
                3'd0: x0 <= BUS_DATA;
                3'd1: y0 <= BUS_DATA;
                3'd2: x1 <= BUS_DATA;
                3'd3: y1 <= BUS_DATA;
                3'd4: ctrl_val <= BUS_DATA[0];
                default: ;
            endcase
        end
    end

    // Fill FSM: validates on START, then walks the rectangle one pixel per clock
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            busy     <= 1'b0;
            fb_we    <= 1'b0;
            fill_val <= 1'b0;
            cx       <= 8'd0;
            cy       <= 7'd0;
            lx0      <= 8'd0;
            lx1      <= 8'd0;
            ly1      <= 7'd0;
            err      <= 1'b0;
        end else begin
            if (bus_wr && offset == 3'd5) begin
                err <= 1'b0;
            end
            case (state)
                IDLE: begin
                    fb_we <= 1'b0;
                    if (start) begin
                        if (start_ok) begin
                            lx0      <= x0;
                            lx1      <= x1;
                            ly1      <= y1[6:0];
                            cx       <= x0;
                            cy       <= y0[6:0];
                            fill_val <= BUS_DATA[0];
                            state    <= FILL;
                            busy     <= 1'b1;
                            fb_we    <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (fill_last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        fb_we <= 1'b0;
                    end else if (cx == lx1) begin
                        cx <= lx0;
                        cy <= cy + 7'd1;
                    end else begin
                        cx <= cx + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef VGA_FILL_IRQ_EN
    // Interrupt latch: set on fill completion or a rejected START, ack wins
    always_ff @(posedge CLK) begin
        if (RESET) begin
            IRQ_RAISE <= 1'b0;
        end else if (IRQ_ACKED) begin
            IRQ_RAISE <= 1'b0;
        end else if (fill_last || (start && !start_ok)) begin
            IRQ_RAISE <= 1'b1;
        end
    end
`endif

    // Registered read path: data and driver enable appear the cycle after the address
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_en   <= 1'b0;
            rd_data <= 8'd0;
        end else begin
            rd_en <= in_range && !BUS_WE;
            case (offset)
                3'd0:    rd_data <= x0;
                3'd1:    rd_data <= y0;
                3'd2:    rd_data <= x1;
                3'd3:    rd_data <= y1;
                3'd4:    rd_data <= {7'd0, ctrl_val};
                3'd5:    rd_data <= {6'd0, err, busy};
                default: rd_data <= 8'd0;
            endcase
        end
    end

    // Never drive the shared bus while the processor is writing
    assign BUS_DATA = (rd_en && !BUS_WE) ? rd_data : 8'bz;

    assign FB_ADDR = {cy, cx};
    assign FB_DATA = fill_val;
    assign FB_WE   = fb_we;
    assign BUSY    = busy;

endmodule

// File: tb/tb_vga_fill_engine.sv
// tb/tb_vga_fill_engine.sv - directed self-checking bench for vga_fill_engine
module tb_vga_fill_engine;

    localparam logic [7:0] BASE = 8'hC0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  bus_addr = 8'h00;
    logic        bus_we = 1'b0;
    logic        tb_drv = 1'b0;
    logic [7:0]  tb_data = 8'h00;
    wire  [7:0]  bus_data;
    logic [14:0] fb_addr;
    logic        fb_data;
    logic        fb_we;
    logic        busy;
`ifdef VGA_FILL_IRQ_EN
    logic        irq_raise;
    logic        irq_acked = 1'b0;
`endif

    int          n_cmp = 0;
    int          n_bad = 0;
    int          we_cnt = 0;
    logic [14:0] mon_addr = '0;
    logic        mon_data = 1'b0;

    assign bus_data = tb_drv ? tb_data : 8'bz;

    always #5 clk = ~clk;

    vga_fill_engine dut (
        .CLK(clk),
        .RESET(reset),
        .BUS_DATA(bus_data),
        .BUS_ADDR(bus_addr),
        .BUS_WE(bus_we),
        .FB_ADDR(fb_addr),
        .FB_DATA(fb_data),
        .FB_WE(fb_we),
`ifdef VGA_FILL_IRQ_EN
        .IRQ_RAISE(irq_raise),
        .IRQ_ACKED(irq_acked),
`endif
        .BUSY(busy)
    );

    always @(negedge clk) begin
        if (fb_we === 1'b1) begin
            we_cnt   <= we_cnt + 1;
            mon_addr <= fb_addr;
            mon_data <= fb_data;
        end
    end

    task automatic bus_write(input logic [2:0] off, input logic [7:0] val);
        bus_addr = BASE + {5'd0, off};
        bus_we   = 1'b1;
        tb_drv   = 1'b1;
        tb_data  = val;
        @(posedge clk);
        #1;
        bus_we   = 1'b0;
        tb_drv   = 1'b0;
        bus_addr = 8'h00;
    endtask

    task automatic bus_read(input logic [2:0] off, output logic [7:0] val);
        bus_addr = BASE + {5'd0, off};
        bus_we   = 1'b0;
        tb_drv   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        val = bus_data;
        bus_addr = 8'h00;
    endtask

    task automatic prog(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        bus_write(3'd0, a);
        bus_write(3'd1, b);
        bus_write(3'd2, c);
        bus_write(3'd3, d);
    endtask

    task automatic run_fill(input int x0, input int y0, input int x1, input int y1,
                            input logic val, output logic [14:0] last);
        int n = 0;
        int bad = 0;
        int ex = x0;
        int ey = y0;
        int exp_n = (x1 - x0 + 1) * (y1 - y0 + 1);
        logic [14:0] ea;
        last = '0;
        for (int c = 0; c < exp_n + 4; c++) begin
            @(negedge clk);
            if (fb_we !== 1'b1) break;
            ea = {ey[6:0], ex[7:0]};
            if (fb_addr !== ea || fb_data !== val || busy !== 1'b1) bad++;
            n++;
            last = fb_addr;
            if (ex == x1) begin
                ex = x0;
                ey++;
            end else begin
                ex++;
            end
        end
        n_cmp++;
        if (n !== exp_n) begin
            n_bad++;
            $display("FAIL fill_count: got %0d want %0d", n, exp_n);
        end
        n_cmp++;
        if (bad !== 0) begin
            n_bad++;
            $display("FAIL fill_pixels: %0d bad cycles want 0", bad);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL fill_busy_fall: got %b want 0", busy);
        end
    endtask

    task automatic test_reset;
        logic [7:0] r;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (fb_we !== 1'b0 || busy !== 1'b0 || fb_addr !== 15'd0 || fb_data !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: we=%b busy=%b addr=%h data=%b want 0", fb_we, busy, fb_addr, fb_data);
        end
        #1 reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus_read(i[2:0], r);
            n_cmp++;
            if (r !== 8'h00) begin
                n_bad++;
                $display("FAIL reset_read_%0d: got %h want 00", i, r);
            end
        end
    endtask

    task automatic test_small_fill;
        logic [14:0] last;
        logic [7:0]  r;
        prog(8'd2, 8'd3, 8'd4, 8'd4);
        bus_write(3'd4, 8'h81);
        run_fill(2, 3, 4, 4, 1'b1, last);
        n_cmp++;
        if (last !== {7'd4, 8'd4}) begin
            n_bad++;
            $display("FAIL small_last_addr: got %h want %h", last, {7'd4, 8'd4});
        end
        bus_read(3'd4, r);
        n_cmp++;
        if (r !== 8'h01) begin
            n_bad++;
            $display("FAIL ctrl_readback: got %h want 01", r);
        end
        bus_read(3'd5, r);
        n_cmp++;
        if (r !== 8'h00) begin
            n_bad++;
            $display("FAIL status_after_fill: got %h want 00", r);
        end
    endtask

    task automatic test_errors;
        logic [7:0] r;
        int         snap;
        logic [7:0] bad_cfg [3][4];
        bad_cfg[0] = '{8'd10, 8'd3, 8'd5, 8'd4};
        bad_cfg[1] = '{8'd0, 8'd0, 8'd160, 8'd4};
        bad_cfg[2] = '{8'd0, 8'd0, 8'd5, 8'd120};
        for (int k = 0; k < 3; k++) begin
            prog(bad_cfg[k][0], bad_cfg[k][1], bad_cfg[k][2], bad_cfg[k][3]);
            snap = we_cnt;
            bus_write(3'd4, 8'h81);
            repeat (4) @(negedge clk);
            n_cmp++;
            if (we_cnt !== snap || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL err_no_write_%0d: writes=%0d busy=%b want 0 0", k, we_cnt - snap, busy);
            end
            bus_read(3'd5, r);
            n_cmp++;
            if (r !== 8'h02) begin
                n_bad++;
                $display("FAIL err_status_%0d: got %h want 02", k, r);
            end
            bus_write(3'd5, 8'h00);
            bus_read(3'd5, r);
            n_cmp++;
            if (r !== 8'h00) begin
                n_bad++;
                $display("FAIL err_clear_%0d: got %h want 00", k, r);
            end
        end
    endtask

    task automatic test_full_screen;
        logic [14:0] last;
        prog(8'd0, 8'd0, 8'd159, 8'd119);
        bus_write(3'd4, 8'h80);
        run_fill(0, 0, 159, 119, 1'b0, last);
        n_cmp++;
        if (last !== {7'd119, 8'd159}) begin
            n_bad++;
            $display("FAIL full_last_addr: got %h want %h", last, {7'd119, 8'd159});
        end
    endtask

    task automatic test_busy_ignore;
        logic [7:0] r;
        int         snap;
        int         cyc;
        prog(8'd0, 8'd0, 8'd9, 8'd1);
        snap = we_cnt;
        bus_write(3'd4, 8'h81);
        bus_write(3'd0, 8'd5);
        bus_write(3'd4, 8'h80);
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (we_cnt - snap !== 20) begin
            n_bad++;
            $display("FAIL busy_ignore_count: got %0d want 20", we_cnt - snap);
        end
        n_cmp++;
        if (mon_addr !== {7'd1, 8'd9} || mon_data !== 1'b1) begin
            n_bad++;
            $display("FAIL busy_ignore_last: got %h/%b want %h/1", mon_addr, mon_data, {7'd1, 8'd9});
        end
        bus_read(3'd0, r);
        n_cmp++;
        if (r !== 8'h00) begin
            n_bad++;
            $display("FAIL busy_ignore_x0: got %h want 00", r);
        end
        bus_read(3'd4, r);
        n_cmp++;
        if (r !== 8'h01) begin
            n_bad++;
            $display("FAIL busy_ignore_ctrl: got %h want 01", r);
        end
    endtask

    task automatic test_back_to_back;
        int snap;
        prog(8'd5, 8'd5, 8'd5, 8'd5);
        snap = we_cnt;
        bus_write(3'd4, 8'h81);
        @(negedge clk);
        n_cmp++;
        if (fb_we !== 1'b1 || fb_addr !== {7'd5, 8'd5}) begin
            n_bad++;
            $display("FAIL single_pixel: we=%b addr=%h want 1 %h", fb_we, fb_addr, {7'd5, 8'd5});
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0 || fb_we !== 1'b0) begin
            n_bad++;
            $display("FAIL single_end: busy=%b we=%b want 0 0", busy, fb_we);
        end
        bus_write(3'd4, 8'h80);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_start: busy=%b want 1", busy);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (we_cnt - snap !== 2 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_count: writes=%0d busy=%b want 2 0", we_cnt - snap, busy);
        end
    endtask

    task automatic test_bus_release;
        logic [7:0] r;
        bus_write(3'd0, 8'h2A);
        bus_read(3'd0, r);
        n_cmp++;
        if (r !== 8'h2A) begin
            n_bad++;
            $display("FAIL x0_readback: got %h want 2a", r);
        end
        bus_addr = BASE + 8'd5;
        bus_we   = 1'b1;
        tb_drv   = 1'b1;
        tb_data  = 8'h00;
        #2;
        n_cmp++;
        if (bus_data !== 8'h00) begin
            n_bad++;
            $display("FAIL bus_contention: got %h want 00", bus_data);
        end
        @(posedge clk);
        #1;
        bus_we = 1'b0;
        tb_drv = 1'b0;
        bus_addr = 8'h00;
    endtask

    task automatic test_reset_mid_fill;
        logic [7:0] r;
        prog(8'd0, 8'd0, 8'd159, 8'd119);
        bus_write(3'd4, 8'h81);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (fb_we !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_fill: we=%b busy=%b want 0 0", fb_we, busy);
        end
        reset = 1'b0;
        bus_read(3'd2, r);
        n_cmp++;
        if (r !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_mid_x1: got %h want 00", r);
        end
    endtask

`ifdef VGA_FILL_IRQ_EN
    task automatic test_irq;
        prog(8'd1, 8'd1, 8'd1, 8'd1);
        bus_write(3'd4, 8'h81);
        @(negedge clk);
        n_cmp++;
        if (irq_raise !== 1'b0) begin
            n_bad++;
            $display("FAIL irq_early: got %b want 0", irq_raise);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (irq_raise !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL irq_rise: irq=%b busy=%b want 1 0", irq_raise, busy);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (irq_raise !== 1'b1) begin
            n_bad++;
            $display("FAIL irq_hold: got %b want 1", irq_raise);
        end
        irq_acked = 1'b1;
        @(posedge clk);
        #1;
        irq_acked = 1'b0;
        n_cmp++;
        if (irq_raise !== 1'b0) begin
            n_bad++;
            $display("FAIL irq_ack: got %b want 0", irq_raise);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_small_fill();
        test_errors();
        test_full_screen();
        test_busy_ignore();
        test_back_to_back();
        test_bus_release();
`ifdef VGA_FILL_IRQ_EN
        test_irq();
`endif
        test_reset_mid_fill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
